// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: default geometry,
// the hardwired zero register address and the clear/run state encoding.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NUM_RD = 2;

  localparam int ZERO_ADDR = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-side bus of the register file: packed read ports,
// write port, reservation port and the ready flag.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) ();

  logic [NUM_RD*ADDR_W-1:0] Rd_Addr;
  logic [NUM_RD*DATA_W-1:0] Rd_Data;
  logic [NUM_RD-1:0]        Rd_Busy;
  logic                     Wr_En;
  logic [ADDR_W-1:0]        Wr_Addr;
  logic [DATA_W-1:0]        Wr_Data;
  logic                     Rsv_En;
  logic [ADDR_W-1:0]        Rsv_Addr;
  logic                     Ready;

  modport master (
    output Rd_Addr, Wr_En, Wr_Addr, Wr_Data, Rsv_En, Rsv_Addr,
    input  Rd_Data, Rd_Busy, Ready
  );

  modport slave (
    input  Rd_Addr, Wr_En, Wr_Addr, Wr_Data, Rsv_En, Rsv_Addr,
    output Rd_Data, Rd_Busy, Ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by a reservation,
// cleared by the matching writeback, looked up per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // Update rule: writeback clears, reservation applied last so a new producer wins
  always_comb begin
    busy_next = busy;
    if (run) begin
      if (wr_en)
        busy_next[wr_addr] = 1'b0;
      if (rsv_en && rsv_addr != ADDR_W'(ZERO_ADDR))
        busy_next[rsv_addr] = 1'b1;
    end
  end

  // Busy bit storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_next;
  end

  // Registered per-port lookup; sees the same-cycle update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_busy <= '0;
    else
      for (int unsigned k = 0; k < NUM_RD; k++)
        rd_busy[k] <= run & busy_next[rd_addr[k*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multiport register file with post-reset hardware clear,
// hardwired zero register and pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding
// (write-first); when undefined, reads return pre-write contents.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input logic      Clk,
  input logic      Rst_n,
  regfile_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  state_t                   state;
  logic [ADDR_W-1:0]        clr_cnt;
  logic                     run;
  logic                     wr_ok;
  logic [DATA_W-1:0]        rd_next [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_q;

  assign run   = (state == ST_RUN);
  assign wr_ok = run && bus.Wr_En && (bus.Wr_Addr != ADDR_W'(ZERO_ADDR));

  // Clear FSM: walk every register once after reset, then run forever
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == ADDR_W'(DEPTH - 1))
        state <= ST_RUN;
    end
  end

  // Storage: zero-fill during clear, writeback port in run (r0 never written)
  always_ff @(posedge Clk) begin
    if (!run)
      mem[clr_cnt] <= '0;
    else if (wr_ok)
      mem[bus.Wr_Addr] <= bus.Wr_Data;
  end

  // Read data selection per port
  always_comb begin
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_next[k] = mem[bus.Rd_Addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && bus.Rd_Addr[k*ADDR_W +: ADDR_W] == bus.Wr_Addr)
        rd_next[k] = bus.Wr_Data;
`endif
    end
  end

  // Registered read ports; forced to zero while clearing
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      rd_data_q <= '0;
    else
      for (int unsigned k = 0; k < NUM_RD; k++)
        rd_data_q[k*DATA_W +: DATA_W] <= run ? rd_next[k] : '0;
  end

  assign bus.Rd_Data = rd_data_q;
  assign bus.Ready   = run;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .run      (run),
    .wr_en    (bus.Wr_En),
    .wr_addr  (bus.Wr_Addr),
    .rsv_en   (bus.Rsv_En),
    .rsv_addr (bus.Rsv_Addr),
    .rd_addr  (bus.Rd_Addr),
    .rd_busy  (bus.Rd_Busy)
  );

endmodule
